// File: rtl/sm_scan_pkg.sv
// Shared definitions for the register-scan display sequencer:
// the scan FSM state encoding and the number of bytes per register word.
package sm_scan_pkg;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHOW    = 3'd3,
    S_NEXT    = 3'd4
  } scan_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sm_dwell_timer.sv
// Dwell timer for the register-scan sequencer. Counts enabled cycles and
// raises tc in the cycle the count sits at DWELL_CYCLES-1 while enabled;
// the count then returns to zero. clr forces the count back to zero and
// wins over counting. While en is low the count holds its value.
// CNT_W must be wide enough that 2^CNT_W > DWELL_CYCLES.
module sm_dwell_timer
  import sm_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count only fires while the timer is actually running.
  assign tc = en && (cnt_q == LAST_CNT);

  // Next count: clear on request or on terminal count, else count when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_reg_scan_ctrl.sv
// Register-scan display sequencer. Sweeps the core register-read port over
// the window addr_lo..addr_hi, latches each 32-bit register and presents it
// one byte at a time (byte 0 first) to a two-digit hex display, each byte
// held for DWELL_CYCLES enabled cycles or until a manual step pulse.
// Optional build macro SM_SCAN_SKIP_ZERO_EN: registers that read as zero are
// skipped, except that after a full silent pass addr_lo is shown anyway.
module sm_reg_scan_ctrl
  import sm_scan_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_data,
  output logic [7:0]        disp_byte,
  output logic [1:0]        byte_idx,
  output logic              data_valid,
  output logic              frame_start
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              data_valid_q, data_valid_d;

  logic              timer_en;
  logic              timer_clr;
  logic              timer_tc;
  logic [ADDR_W-1:0] eff_hi;
  logic              at_window_end;
  logic              show_ok;

  // An inverted window collapses to the single register addr_lo.
  assign eff_hi        = (addr_hi < addr_lo) ? addr_lo : addr_hi;
  // Treat anything at or past the end as the end, so a window that shrinks
  // mid-scan still returns to addr_lo instead of running off to the top.
  assign at_window_end = (reg_addr_q >= eff_hi);

`ifdef SM_SCAN_SKIP_ZERO_EN
  logic shown_q, shown_d;   // some register was displayed in this pass
  logic force_q, force_d;   // previous pass was silent: show next capture

  assign show_ok = (reg_data != 32'd0) || force_q;

  // Per-pass bookkeeping for zero skipping.
  always_comb begin
    shown_d = shown_q;
    force_d = force_q;
    case (state_q)
      S_LOAD: begin
        shown_d = 1'b0;
        force_d = 1'b0;
      end
      S_CAPTURE: begin
        if (show_ok) begin
          shown_d = 1'b1;
          force_d = 1'b0;
        end
      end
      S_NEXT: begin
        if (at_window_end) begin
          force_d = ~shown_q;
          shown_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Pass flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_q <= 1'b0;
      force_q <= 1'b0;
    end else begin
      shown_q <= shown_d;
      force_q <= force_d;
    end
  end
`else
  assign show_ok = 1'b1;
`endif

  sm_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dwell_timer (
    .clk (clk),
    .rst (rst),
    .en  (timer_en),
    .clr (timer_clr),
    .tc  (timer_tc)
  );

  // Next-state, datapath updates and the frame_start strobe.
  always_comb begin
    state_d      = state_q;
    reg_addr_d   = reg_addr_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    data_valid_d = data_valid_q;
    frame_start  = 1'b0;
    timer_en     = 1'b0;
    timer_clr    = 1'b0;
    case (state_q)
      S_LOAD: begin
        reg_addr_d   = addr_lo;
        data_valid_d = 1'b0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (show_ok) begin
          word_d       = reg_data;
          byte_idx_d   = 2'd0;
          timer_clr    = 1'b1;
          frame_start  = 1'b1;
          data_valid_d = 1'b1;
          state_d      = S_SHOW;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_SHOW: begin
        timer_en = scan_en;
        // step and terminal count together are a single advance.
        if (timer_tc || step) begin
          timer_clr = 1'b1;
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        reg_addr_d   = at_window_end ? addr_lo : reg_addr_q + 1'b1;
        data_valid_d = 1'b0;
        state_d      = S_SETTLE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      reg_addr_q   <= '0;
      word_q       <= '0;
      byte_idx_q   <= 2'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_addr_q   <= reg_addr_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign reg_addr   = reg_addr_q;
  assign byte_idx   = byte_idx_q;
  assign data_valid = data_valid_q;
  assign disp_byte  = word_q[8*byte_idx_q +: 8];

endmodule

// File: tb/tb_sm_reg_scan_ctrl.sv
// Testbench for sm_reg_scan_ctrl (DWELL_CYCLES=4). A register file model
// drives reg_data from reg_addr. Expected frames are pushed to a scoreboard
// queue and popped when frame_start is seen; hand sequences cover timing,
// freeze/step, coincident advance and asynchronous reset.
module tb_sm_reg_scan_ctrl;

  localparam int ADDR_W = 4;
  localparam int DWELL  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_en;
  logic              step;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_data;
  logic [7:0]        disp_byte;
  logic [1:0]        byte_idx;
  logic              data_valid;
  logic              frame_start;

  logic [31:0] regs [16];
  assign reg_data = regs[reg_addr];

  always #5 clk = ~clk;

  sm_reg_scan_ctrl #(
    .ADDR_W       (ADDR_W),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .step        (step),
    .addr_lo     (addr_lo),
    .addr_hi     (addr_hi),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .disp_byte   (disp_byte),
    .byte_idx    (byte_idx),
    .data_valid  (data_valid),
    .frame_start (frame_start)
  );

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] word;
  } frame_t;

  typedef struct packed {
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [15:0] exp;   // expected frame addresses, first one in [3:0]
  } scan_vec_t;

  frame_t      sb_q [$];
  logic        mon_en = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: each frame_start must match the next expected frame,
  // and the following cycle must show byte 0 of the expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        check("sb_byte0", {24'd0, disp_byte}, {24'd0, pend_word[7:0]});
        pend = 1'b0;
      end
      if (frame_start === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL sb_extra_frame: got frame at addr %0d, required no frame", reg_addr);
        end else begin
          frame_t e;
          e = sb_q.pop_front();
          $display("frame addr=%0d expected_addr=%0d word=0x%08h", reg_addr, e.addr, e.word);
          check("sb_addr", {28'd0, reg_addr}, {28'd0, e.addr});
          pend_word = e.word;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic do_reset(input logic [3:0] lo, input logic [3:0] hi);
    rst = 1'b1;
    step = 1'b0;
    scan_en = 1'b1;
    addr_lo = lo;
    addr_hi = hi;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_queue_empty(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() == 0) passes++;
    else begin
      $display("FAIL %s: got %0d frames outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, frame_start}, 32'd1);
  endtask

  task automatic wait_byte(input string name, input logic [1:0] idx);
    int n = 0;
    while (byte_idx !== idx && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {30'd0, byte_idx}, {30'd0, idx});
  endtask

  task automatic push_frame(input logic [3:0] a);
    frame_t e;
    e.addr = a;
    e.word = regs[a];
    sb_q.push_back(e);
  endtask

  scan_vec_t vecs [5];
  logic [7:0] t1_bytes [4];

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE0000 | (i << 8) | (i + 1);
    regs[2] = 32'h11223344;
    regs[3] = 32'hAABBCCDD;
    t1_bytes[0] = 8'h44;
    t1_bytes[1] = 8'h33;
    t1_bytes[2] = 8'h22;
    t1_bytes[3] = 8'h11;
    vecs[0] = '{lo: 4'd2,  hi: 4'd3,  exp: 16'h3232};
    vecs[1] = '{lo: 4'd14, hi: 4'd15, exp: 16'hFEFE};
    vecs[2] = '{lo: 4'd15, hi: 4'd15, exp: 16'hFFFF};
    vecs[3] = '{lo: 4'd5,  hi: 4'd1,  exp: 16'h5555};
    vecs[4] = '{lo: 4'd0,  hi: 4'd2,  exp: 16'h0210};

    // Reset values and basic timing, window 2..3.
    rst = 1'b1;
    step = 1'b0;
    scan_en = 1'b1;
    addr_lo = 4'd2;
    addr_hi = 4'd3;
    @(negedge clk);
    check("rst_reg_addr", {28'd0, reg_addr}, 32'd0);
    check("rst_disp_byte", {24'd0, disp_byte}, 32'd0);
    check("rst_byte_idx", {30'd0, byte_idx}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);                       // SETTLE
    check("t1_addr_settle", {28'd0, reg_addr}, 32'd2);
    check("t1_no_fs_settle", {31'd0, frame_start}, 32'd0);
    step = 1'b1;                          // ignored outside SHOW
    @(negedge clk);                       // CAPTURE
    step = 1'b0;
    check("t1_fs_cycle3", {31'd0, frame_start}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      $display("t1 cycle %0d disp=0x%02h idx=%0d dv=%0b", i, disp_byte, byte_idx, data_valid);
      check("t1_disp", {24'd0, disp_byte}, {24'd0, t1_bytes[i/4]});
      check("t1_idx", {30'd0, byte_idx}, i / 4);
      check("t1_dv", {31'd0, data_valid}, 32'd1);
    end
    @(negedge clk);                       // NEXT
    @(negedge clk);                       // SETTLE
    check("t1_next_addr", {28'd0, reg_addr}, 32'd3);
    check("t1_dv_low", {31'd0, data_valid}, 32'd0);
    @(negedge clk);                       // CAPTURE
    check("t1_fs_reg3", {31'd0, frame_start}, 32'd1);
    @(negedge clk);
    check("t1_reg3_byte0", {24'd0, disp_byte}, 32'hDD);

    // Table-driven windows through the scoreboard.
    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].lo, vecs[v].hi);
      for (int k = 0; k < 4; k++) push_frame(vecs[v].exp[4*k +: 4]);
      mon_en = 1'b1;
      wait_queue_empty("vec_frames", 150);
      mon_en = 1'b0;
      pend = 1'b0;
    end

    // Freeze with scan_en=0, manual step, step coincident with terminal count.
    do_reset(4'd4, 4'd4);
    wait_frame("t2_frame");
    scan_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_frozen_idx", {30'd0, byte_idx}, 32'd0);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("t2_step_idx", {30'd0, byte_idx}, 32'd1);
    scan_en = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b1;                          // counter now at terminal count
    @(negedge clk);
    step = 1'b0;
    check("t2_coinc_idx", {30'd0, byte_idx}, 32'd2);
    repeat (3) @(negedge clk);
    check("t2_coinc_hold", {30'd0, byte_idx}, 32'd2);
    @(negedge clk);
    check("t2_coinc_next", {30'd0, byte_idx}, 32'd3);

    // Asynchronous reset during byte 2, then restart from addr_lo.
    do_reset(4'd2, 4'd3);
    wait_byte("t3_reach_byte2", 2'd2);
    rst = 1'b1;
    #1;
    check("t3_rst_addr", {28'd0, reg_addr}, 32'd0);
    check("t3_rst_disp", {24'd0, disp_byte}, 32'd0);
    check("t3_rst_idx", {30'd0, byte_idx}, 32'd0);
    check("t3_rst_dv", {31'd0, data_valid}, 32'd0);
    check("t3_rst_fs", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    push_frame(4'd2);
    mon_en = 1'b1;
    rst = 1'b0;
    wait_queue_empty("t3_restart", 50);
    mon_en = 1'b0;
    pend = 1'b0;

`ifdef SM_SCAN_SKIP_ZERO_EN
    // Zero registers are skipped; a silent pass forces addr_lo next pass.
    regs[2] = 32'd0;
    regs[3] = 32'd5;
    regs[4] = 32'd0;
    do_reset(4'd2, 4'd4);
    for (int k = 0; k < 3; k++) push_frame(4'd3);
    mon_en = 1'b1;
    wait_queue_empty("sz_skip", 200);
    mon_en = 1'b0;
    pend = 1'b0;
    regs[0] = 32'd0;
    regs[1] = 32'd0;
    do_reset(4'd0, 4'd1);
    for (int k = 0; k < 2; k++) push_frame(4'd0);
    mon_en = 1'b1;
    wait_queue_empty("sz_all_zero", 200);
    mon_en = 1'b0;
    pend = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sm_reg_scan_ctrl.md
Name: sm_reg_scan_ctrl

Overview:
Sequencer that sweeps the register-read port of the processor core across an address window and presents each register a byte at a time to a 2-digit hex display. For each register, it drives the read address, waits for data to settle, latches the 32-bit value, then shows bytes 0..3 with a programmable dwell per byte. It replaces the hard-wired register-0 view on the board top and feeds the existing hex-digit decoders and LEDs.

Parameters:
- ADDR_W, 4, width of the register read address
- DWELL_CYCLES, 50000000, clock cycles each byte is displayed (1 s at 50 MHz); legal range ≥ 2
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES

Ports:
- clk  in  1  system clock (50 MHz board clock)
- rst  in  1  asynchronous, active-high reset
- scan_en  in  1  level; 1 = dwell timer runs, 0 = frozen on current byte
- step  in  1  single-cycle pulse (already debounced/synchronised); manual advance to next byte
- addr_lo  in  ADDR_W  first register of the window
- addr_hi  in  ADDR_W  last register of the window
- reg_addr  out  ADDR_W  register read address to core
- reg_data  in  32  register read data from core (combinational from reg_addr)
- disp_byte  out  8  byte to hex display: hi nibble → digit 1, lo nibble → digit 0
- byte_idx  out  2  index of byte currently shown (0 = bits 7:0)
- data_valid  out  1  1 while disp_byte holds captured data
- frame_start  out  1  one-cycle pulse when a new register is captured

Behaviour:
- Reset values: reg_addr=0, disp_byte=0, byte_idx=0, data_valid=0, frame_start=0, dwell counter=0, captured word=0, FSM=S_LOAD.
- Effective window: if addr_hi < addr_lo, scan addr_lo only. addr_lo/addr_hi are sampled in S_LOAD and S_NEXT only.
- FSM:
  - S_LOAD: reg_addr←addr_lo, data_valid←0 → S_SETTLE.
  - S_SETTLE: one cycle wait for reg_data → S_CAPTURE.
  - S_CAPTURE: word←reg_data, byte_idx←0, counter←0, frame_start=1 for this cycle, data_valid←1 → S_SHOW.
  - S_SHOW: disp_byte = word[8*byte_idx +: 8]. The counter increments when scan_en=1. Advance event occurs when counter reaches DWELL_CYCLES-1 or when step=1. Both in the same cycle count as one advance. On advance: counter←0; if byte_idx<3, byte_idx+1; else → S_NEXT.
  - S_NEXT: reg_addr←(reg_addr==eff_hi) ? addr_lo : reg_addr+1, data_valid←0 → S_SETTLE.
- Latency: from register-change advance to the new data on disp_byte is 3 cycles (NEXT, SETTLE, CAPTURE).
- The captured word is frozen during S_SHOW. Core writes to the shown register are not reflected until the next visit.
- Wrap-around: addr_hi=all-ones wraps to addr_lo without overflow. A window of a single register recaptures the same address each pass.
- step in a non-SHOW state is ignored (not queued).
- scan_en=0: counter holds its value; step still advances.
- Asynchronous reset mid-scan returns all outputs to reset values immediately. Scanning restarts from addr_lo.

Optional Feature:
- SM_SCAN_SKIP_ZERO_EN: when defined, S_CAPTURE checks reg_data. If it is 0, the FSM goes directly to S_NEXT with no frame_start and data_valid kept 0. A per-pass flag records whether any register was shown. If a full pass shows nothing, the next capture of addr_lo is displayed regardless (no infinite silent loop).
- Without the macro, every register in the window is displayed.

Decomposition:
- Shared package sm_scan_pkg: FSM state enum (S_LOAD, S_SETTLE, S_CAPTURE, S_SHOW, S_NEXT) and the byte-count constant 4.
- One natural sub-module, sm_dwell_timer: counter with enable, clear and terminal-count pulse.
- Byte mux and address logic stay in the top.

Test Plan:
- Reset, addr_lo=2, addr_hi=3, DWELL_CYCLES=4, scan_en=1, reg2=0x11223344 → reg_addr=2; frame_start pulse on cycle 3; disp_byte 0x44,0x33,0x22,0x11 for 4 cycles each; then reg_addr=3.
- Window addr_lo=14, addr_hi=15 → after reg 15 byte 3, reg_addr returns to 14 (wrap). Repeat with addr_lo=addr_hi=15 → recaptures 15.
- scan_en=0 in S_SHOW for 20 cycles → byte_idx constant. One step pulse → byte_idx+1. step coincident with terminal count → exactly one advance.
- addr_hi=1 < addr_lo=5 → only register 5 ever addressed.
- Assert rst during S_SHOW of byte 2 → same-cycle outputs zero. After release, first capture is from addr_lo.
- With SM_SCAN_SKIP_ZERO_EN, regs 2..4 = {0,0x5,0} → only reg 3 displayed. All regs zero → addr_lo displayed every second pass.
